// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings, register index width,
// control-output bundle and the load-use hazard predicate.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MULDIV  = 2'd1,
    ST_MEMWAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE   = '{pc_write: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b0, id_ex_hold: 1'b0};
  localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_stall: 1'b0, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b0, id_ex_hold: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b0, id_ex_hold: 1'b1};
  localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_stall: 1'b0, if_id_flush: 1'b1,
                                       id_ex_bubble: 1'b1, id_ex_hold: 1'b0};
  localparam hz_ctrl_t CTRL_LDUSE  = '{pc_write: 1'b0, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                       id_ex_bubble: 1'b1, id_ex_hold: 1'b0};

  // A load into r0 never creates a dependency; rt only matters when the ID op reads it.
  function automatic logic load_use_hazard(input logic     ex_mem_read,
                                           input reg_idx_t ex_rt,
                                           input reg_idx_t rs_id,
                                           input reg_idx_t rt_id,
                                           input logic     uses_rt_id);
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == rs_id) || (uses_rt_id && (ex_rt == rt_id)));
  endfunction

endpackage

// File: rtl/muldiv_stall_counter.sv
// Down-counter tracking the remaining EX occupancy of a mult/div; done marks the last busy cycle.
module muldiv_stall_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         count <= '0;
    else if (load)                     count <= load_value;
    else if (decrement && count != '0) count <= count - 1'b1;
  end

  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, mult/div and memory freezes.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush statistics counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rs_id,
  input  logic [REG_IDX_W-1:0] rt_id,
  input  logic                 uses_rt_id,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic                 branch_taken_ex,
  input  logic                 muldiv_start_ex,
  input  logic                 mem_stall,
  output logic                 pc_write,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 id_ex_hold,
  output logic [1:0]           state
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count
`endif
);

  localparam int CNT_W = $clog2(MULDIV_LATENCY) + 1;

  hz_state_e        cur_state, next_state;
  hz_ctrl_t         ctrl;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_value;
  logic             hazard;

  assign hazard = load_use_hazard(ex_mem_read, ex_rt, rs_id, rt_id, uses_rt_id);
  assign cnt_dec = (cur_state == ST_MULDIV);

  muldiv_stall_counter #(.WIDTH(CNT_W)) u_muldiv_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (CNT_W'(MULDIV_LATENCY - 1)),
    .decrement  (cnt_dec),
    .count      (cnt_value),
    .done       (cnt_done)
  );

  // The first cycle after a memory wait is an ordinary RUN cycle, so events seen there
  // (branch, load-use, mult/div start) are acted on rather than dropped.
  always_comb begin
    ctrl       = CTRL_RUN;
    next_state = cur_state;
    cnt_load   = 1'b0;
    case (cur_state)
      ST_MULDIV: begin
        ctrl = CTRL_FREEZE;
        if (cnt_done) next_state = ST_RUN;
      end
      ST_RUN, ST_MEMWAIT: begin
        next_state = ST_RUN;
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          next_state = ST_MEMWAIT;
        end else if (branch_taken_ex) begin
          ctrl = CTRL_FLUSH;
        end else if (hazard) begin
          ctrl = CTRL_LDUSE;
        end else if (muldiv_start_ex) begin
          cnt_load   = 1'b1;
          next_state = ST_MULDIV;
        end
      end
      default: next_state = ST_RUN;
    endcase
    if (reset) ctrl = CTRL_NONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur_state <= ST_RUN;
    else       cur_state <= next_state;
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign id_ex_hold   = ctrl.id_ex_hold;
  assign state        = cur_state;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!ctrl.pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (ctrl.if_id_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized scoreboard bench for hazard_control_unit against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int LAT = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_id = '0, rt_id = '0, ex_rt = '0;
  logic       uses_rt_id = 1'b0, ex_mem_read = 1'b0, branch_taken_ex = 1'b0;
  logic       muldiv_start_ex = 1'b0, mem_stall = 1'b0;
  logic       pc_write, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold;
  logic [1:0] state;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_control_unit #(.MULDIV_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken_ex(branch_taken_ex),
    .muldiv_start_ex(muldiv_start_ex), .mem_stall(mem_stall), .pc_write(pc_write),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .id_ex_hold(id_ex_hold), .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [4:0]  outs;   // pc_write, stall, flush, bubble, hold
    logic [1:0]  st;
    longint      stalls;
    longint      flushes;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     stim_done = 0;

  // Model: mode 0=running, 1=mult/div busy, 2=waiting on memory; rem = busy cycles still owed.
  int     m_mode = 0;
  int     m_rem  = 0;
  longint m_stalls = 0, m_flushes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input string tag, input bit rst, input int rs, input int rt, input bit urt,
                       input bit mr, input int ert, input bit br, input bit ms, input bit ml);
    exp_t e;
    bit   hz;
    @(posedge clock); #1;
    reset = rst; rs_id = 5'(rs); rt_id = 5'(rt); uses_rt_id = urt; ex_mem_read = mr;
    ex_rt = 5'(ert); branch_taken_ex = br; mem_stall = ms; muldiv_start_ex = ml;
    hz = mr && ert != 0 && (ert == rs || (urt && ert == rt));
    e.tag = tag; e.stalls = m_stalls; e.flushes = m_flushes;
    if (rst) begin
      m_mode = 0; m_rem = 0; m_stalls = 0; m_flushes = 0;
      e.stalls = 0; e.flushes = 0;
      e.outs = 5'b00000; e.st = 2'd0;
    end else begin
      e.st = 2'(m_mode);
      if (m_mode == 1) begin
        e.outs = 5'b01001;
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end else if (m_mode == 2 && ms) begin
        e.outs = 5'b01001;
      end else begin
        m_mode = 0;
        if (ms)             begin e.outs = 5'b01001; m_mode = 2; end
        else if (br)        e.outs = 5'b10110;
        else if (hz)        e.outs = 5'b01010;
        else if (ml)        begin e.outs = 5'b10000; m_mode = 1; m_rem = LAT - 1; end
        else                e.outs = 5'b10000;
      end
      if (!e.outs[4] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (e.outs[2] && m_flushes < 64'hFFFF_FFFF) m_flushes++;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".outs"}, {pc_write, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold}, e.outs);
        check({e.tag, ".state"}, state, e.st);
        check({e.tag, ".stall_and_flush"}, if_id_stall & if_id_flush, 0);
`ifdef HAZARD_STATS_EN
        check({e.tag, ".stall_cycles"}, stall_cycles, e.stalls);
        check({e.tag, ".flush_count"}, flush_count, e.flushes);
`endif
      end
    end
  end

  initial begin : stimulus
    int wait_cnt;
    drive("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("reset", 1, 5, 5, 1, 1, 5, 1, 1, 1);
    drive("load_use", 0, 5, 0, 0, 1, 5, 0, 0, 0);
    drive("after_load_use", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("r0_load", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive("rt_unused", 0, 1, 7, 0, 1, 7, 0, 0, 0);
    drive("branch_over_hazard", 0, 5, 0, 0, 1, 5, 1, 0, 0);
    drive("after_branch", 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    #2;
    check("stats_stall_direct", stall_cycles, 1);
    check("stats_flush_direct", flush_count, 1);
`endif
    drive("rt_hazard", 0, 1, 9, 1, 1, 9, 0, 0, 0);
    drive("muldiv_start", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive("muldiv_busy", 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(4);
    drive("mem_stall", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("mem_stall", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("mem_stall", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    drive("muldiv_start", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive("muldiv_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("reset_mid_muldiv", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("post_reset", 0, 3, 0, 0, 1, 3, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      drive("random", ($urandom_range(0, 199) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 10));
    end
    idle(2);
    stim_done = 1;
    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(posedge clock);
      wait_cnt++;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter MULDIV_LATENCY, default 4, EX-stage mult/div occupancy in cycles (legal 2..64).
REQ-002 SHALL have ports:
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous, active-high reset
  rs_id  in  5  ID-stage source register rs
  rt_id  in  5  ID-stage source register rt
  uses_rt_id  in  1  ID instruction reads rt
  ex_mem_read  in  1  EX instruction is a load
  ex_rt  in  5  EX load destination register
  branch_taken_ex  in  1  EX resolved a taken branch/jump
  muldiv_start_ex  in  1  mult/div entered EX this cycle
  mem_stall  in  1  data memory not ready
  pc_write  out  1  PC update enable
  if_id_stall  out  1  IF/ID hold
  if_id_flush  out  1  IF/ID clear
  id_ex_bubble  out  1  ID/EX loads NOP
  id_ex_hold  out  1  ID/EX holds contents
  state  out  2  current FSM state
REQ-003 Reset SHALL be `reset`, asynchronous, active-high; clock SHALL be `clock`.

Function
REQ-004 FSM states SHALL be RUN (0), MULDIV (1), MEMWAIT (2); outputs SHALL be Mealy (same-cycle from state and inputs).
REQ-005 RUN event priority SHALL be mem_stall > branch_taken_ex > load-use > muldiv_start_ex.
REQ-006 Load-use SHALL be ex_mem_read && ex_rt!=0 && (ex_rt==rs_id || (uses_rt_id && ex_rt==rt_id)); response: pc_write=0, if_id_stall=1, id_ex_bubble=1 for that cycle only, state stays RUN.
REQ-007 Taken branch in RUN SHALL give pc_write=1, if_id_flush=1, id_ex_bubble=1, no stall; branch with simultaneous load-use SHALL flush only.
REQ-008 muldiv_start_ex in RUN SHALL load counter with MULDIV_LATENCY-1 and enter MULDIV next edge.
REQ-009 In MULDIV: pc_write=0, if_id_stall=1, id_ex_hold=1, others 0; counter decrements each cycle; at counter==1 and decrementing, next state RUN; mem_stall and branch_taken_ex SHALL be ignored.
REQ-010 mem_stall in RUN SHALL freeze same cycle (pc_write=0, if_id_stall=1, id_ex_hold=1) and enter MEMWAIT; MEMWAIT SHALL keep freeze while mem_stall=1 and return to RUN on the first cycle mem_stall=0 (that cycle unfrozen).
REQ-011 RUN with no event SHALL output pc_write=1, all others 0.
REQ-012 Outputs if_id_flush and if_id_stall SHALL never be both 1.

Reset
REQ-013 While reset=1: state=RUN, counter=0, pc_write=0, all other outputs 0.
REQ-014 Reset during MULDIV or MEMWAIT SHALL abort immediately to RUN; first post-reset cycle behaves as RUN.

Configuration
REQ-015 Macro HAZARD_STATS_EN SHALL add outputs stall_cycles[31:0] (cycles with pc_write=0 outside reset) and flush_count[31:0] (cycles with if_id_flush=1), both saturating at 0xFFFFFFFF, reset to 0.
REQ-016 Without HAZARD_STATS_EN the ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-017 Shared package pipeline_pkg SHALL hold state encodings, REG_ZERO=5'd0 and register-index width 5.
REQ-018 The MULDIV down-counter SHALL be sub-module muldiv_stall_counter (load, decrement, done flag), width $clog2(MULDIV_LATENCY)+1.

Verification
REQ-019 Load-use: ex_mem_read=1, ex_rt=5, rs_id=5 -> one cycle pc_write=0, if_id_stall=1, id_ex_bubble=1; next cycle pc_write=1.
REQ-020 ex_rt=0 with rs_id=0, ex_mem_read=1 -> no stall; ex_rt=7, rt_id=7, uses_rt_id=0 -> no stall.
REQ-021 branch_taken_ex=1 with load-use hazard present -> if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_stall=0.
REQ-022 muldiv_start_ex pulse, MULDIV_LATENCY=4 -> state=MULDIV for exactly 3 cycles after start cycle, pc_write=0 throughout, RUN after.
REQ-023 mem_stall high 3 cycles -> freeze 3 cycles, state=MEMWAIT 2 cycles; reset asserted mid-MULDIV -> state=RUN, outputs per REQ-013 immediately.
REQ-024 With HAZARD_STATS_EN: scenarios REQ-019+REQ-021 -> stall_cycles=1, flush_count=1.
